ysyx_22050078_pipe_ctrl: RTL and testbench
==========================================

// Module: ysyx_22050078_pipe_ctrl
// PURPOSE
//  Hazard/sequencing controller for the 5-stage pipeline registers (IF/ID, ID/EX, EX/LS, LS/WB) and the PC.
//  Generates per-register write-enable (stall) and bubble (flush, NOP inject) controls from load-use,
//  branch-redirect and memory-busy events. Also keeps a small FSM for multi-cycle flush and memory wait,
//  plus perf counters.
// PARAMETERS
//  REG_AW     5   architectural register index width
//  FLUSH_CYC  1   cycles of IF/ID bubble after a redirect (covers IFU fetch latency), 1..15
//  CNT_W      32  perf counter width
// PORTS
//  i_clk            in   1       clock
//  i_rst_n          in   1       async active-low reset
//  i_idu_rs1        in   REG_AW  ID-stage source 1 index
//  i_idu_rs1_en     in   1       ID-stage reads rs1
//  i_idu_rs2        in   REG_AW  ID-stage source 2 index
//  i_idu_rs2_en     in   1       ID-stage reads rs2
//  i_exu_rd         in   REG_AW  EX-stage destination index
//  i_exu_ld         in   1       EX-stage instruction is a load
//  i_exu_redirect   in   1       EX resolved taken branch/jump (PC mispredicted)
//  i_lsu_busy       in   1       LSU multi-cycle access in progress
//  o_pc_wen         out  1       PC register update enable
//  o_ifid_wen       out  1       IF/ID write enable
//  o_ifid_bubble    out  1       IF/ID inject NOP (0x13)
//  o_idex_wen       out  1       ID/EX write enable
//  o_idex_bubble    out  1       ID/EX inject NOP
//  o_exls_wen       out  1       EX/LS write enable
//  o_lswb_wen       out  1       LS/WB write enable
//  o_lswb_bubble    out  1       LS/WB inject NOP (LSU still busy)
//  o_stall_cnt      out  CNT_W   cycles with o_pc_wen==0
//  o_flush_cnt      out  CNT_W   redirects accepted
// BEHAVIOUR
//  Reset (i_rst_n==0, async): state=RUN, fl_cnt=0, both perf counters=0.
//   While in reset: all *_wen=0, all *_bubble=1.
//  Control outputs are combinational from state + inputs, acting in the same cycle.
//   The state and counters are registered on i_clk rising edge.
//  lu_haz = i_exu_ld & (i_exu_rd!=0) & ((i_idu_rs1_en & rs1==rd) | (i_idu_rs2_en & rs2==rd)).
//  Priority each cycle: i_lsu_busy > i_exu_redirect > FLUSH state > lu_haz > normal.
//  States:
//   RUN:   default outputs are all wen=1 and all bubble=0.
//          If i_lsu_busy: go to MEM_WAIT.
//            All wen=0 except o_lswb_wen=1 with o_lswb_bubble=1. Nothing else moves.
//          Else if i_exu_redirect: o_ifid_bubble=1 and o_idex_bubble=1, with all wen=1.
//            The PC takes the target. Count flush. If FLUSH_CYC>1, go to FLUSH with fl_cnt=FLUSH_CYC-1.
//          Else if lu_haz: o_pc_wen=0 and o_ifid_wen=0; o_idex_bubble=1, others wen=1.
//            This is exactly 1 cycle: next cycle the load is in LS and lu_haz clears by itself. No state.
//   MEM_WAIT: same outputs as the busy case above while i_lsu_busy=1.
//          When i_lsu_busy falls: return to RUN in that cycle and evaluate RUN rules combinationally.
//            A redirect held in EX during the wait is therefore taken on the first non-busy cycle, not lost.
//   FLUSH: o_ifid_bubble=1, all wen=1; fl_cnt decrements each cycle; go to RUN when fl_cnt reaches 1.
//          lu_haz is ignored (ID holds a bubble).
//          A new redirect restarts fl_cnt=FLUSH_CYC-1 and counts again.
//          i_lsu_busy preempts: go to MEM_WAIT and drop the remaining flush cycles.
//            Safe because IF/ID is frozen holding a bubble.
//  Never: wen=0 together with bubble=1 on the same register.
//   The one exception is reset (bubble is don't-care while wen=0).
//  o_stall_cnt increments when o_pc_wen==0 (not during reset). Counters wrap modulo 2^CNT_W.
//  Reset asserted mid-stall or mid-flush: immediate return to RUN; no pending event is remembered.
// STRUCTURE
//  State encoding (RUN/MEM_WAIT/FLUSH) and the NOP constant 0x13 go in defines.v next to CPU_WIDTH/INS_WIDTH.
//  Sub-module: hazard detect comparator ysyx_22050078_lu_detect (combinational, produces lu_haz).
//  FSM state and counters are held in stl_reg instances.
// TESTING
//  1. ld x5 in EX, ID reads rs1=x5 -> 1 cycle: pc_wen=0, ifid_wen=0, idex_bubble=1; next cycle all wen=1.
//  2. ld x0 in EX, ID reads x0 -> no stall; rs2_en=0 with rs2==rd -> no stall.
//  3. redirect with FLUSH_CYC=3 -> ifid_bubble=1 for 3 cycles; idex_bubble=1 only in the first; flush_cnt+=1.
//  4. lsu_busy high 4 cycles with redirect held -> 4 cycles all frozen, lswb_bubble=1, stall_cnt+=4.
//     Redirect is taken in cycle 5.
//  5. lu_haz and redirect in the same cycle -> redirect wins: pc_wen=1, both bubbles=1.
//  6. Assert i_rst_n=0 asynchronously inside FLUSH -> outputs go to reset values before the next edge.
//     After release, state=RUN and counters=0.

Source files
------------

// File: rtl/ysyx_22050078_pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_pipe_ctrl_pkg
//   Shared constants and types for the pipeline hazard/sequencing controller:
//   FSM state encoding, the canonical NOP instruction, and the bundle of
//   per-pipeline-register control bits with helpers for the common patterns.
// ---------------------------------------------------------------------------
package ysyx_22050078_pipe_ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH    = 2'd2;

    // addi x0, x0, 0 -- what a bubbled pipeline register holds
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic pc_wen;
        logic ifid_wen;
        logic ifid_bubble;
        logic idex_wen;
        logic idex_bubble;
        logic exls_wen;
        logic lswb_wen;
        logic lswb_bubble;
    } pipe_ctrl_t;

    // Everything advances, nothing is squashed.
    function automatic pipe_ctrl_t ctrl_run();
        pipe_ctrl_t c;
        c = '{pc_wen: 1'b1, ifid_wen: 1'b1, ifid_bubble: 1'b0, idex_wen: 1'b1,
              idex_bubble: 1'b0, exls_wen: 1'b1, lswb_wen: 1'b1, lswb_bubble: 1'b0};
        return c;
    endfunction

    // LSU busy: freeze the front of the pipe, keep writing a NOP into LS/WB
    // so the incomplete access never retires twice.
    function automatic pipe_ctrl_t ctrl_busy();
        pipe_ctrl_t c;
        c = '{pc_wen: 1'b0, ifid_wen: 1'b0, ifid_bubble: 1'b0, idex_wen: 1'b0,
              idex_bubble: 1'b0, exls_wen: 1'b0, lswb_wen: 1'b1, lswb_bubble: 1'b1};
        return c;
    endfunction

    // Held in reset: nothing written, bubble bits asserted.
    function automatic pipe_ctrl_t ctrl_reset();
        pipe_ctrl_t c;
        c = '{pc_wen: 1'b0, ifid_wen: 1'b0, ifid_bubble: 1'b1, idex_wen: 1'b0,
              idex_bubble: 1'b1, exls_wen: 1'b0, lswb_wen: 1'b0, lswb_bubble: 1'b1};
        return c;
    endfunction

endpackage

// File: rtl/ysyx_22050078_lu_detect.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_lu_detect
//   Load-use hazard comparator (purely combinational).
//   Ports:
//     i_idu_rs1/_en, i_idu_rs2/_en : ID-stage source indices and read enables
//     i_exu_rd, i_exu_ld           : EX-stage destination and "is a load"
//     o_lu_haz                     : ID needs the value the EX load produces
// ---------------------------------------------------------------------------
module ysyx_22050078_lu_detect #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_idu_rs1,
    input  logic              i_idu_rs1_en,
    input  logic [REG_AW-1:0] i_idu_rs2,
    input  logic              i_idu_rs2_en,
    input  logic [REG_AW-1:0] i_exu_rd,
    input  logic              i_exu_ld,
    output logic              o_lu_haz
);

    // x0 is hardwired to zero, so a load into x0 never produces a dependency.
    assign o_lu_haz = i_exu_ld && (i_exu_rd != '0) &&
                      ((i_idu_rs1_en && (i_idu_rs1 == i_exu_rd)) ||
                       (i_idu_rs2_en && (i_idu_rs2 == i_exu_rd)));

endmodule

// File: rtl/ysyx_22050078_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22050078_pipe_ctrl
//   Stall/flush controller for the PC and the IF/ID, ID/EX, EX/LS, LS/WB
//   pipeline registers. Controls are combinational from state + inputs;
//   state and perf counters update on the rising clock edge.
//   Ports:
//     i_clk, i_rst_n            : clock, async active-low reset
//     i_idu_*, i_exu_rd/_ld     : operands for load-use detection
//     i_exu_redirect            : EX resolved a mispredicted branch/jump
//     i_lsu_busy                : LSU multi-cycle access in progress
//     o_*_wen / o_*_bubble      : per-register write enable / NOP inject
//     o_stall_cnt               : cycles with o_pc_wen low
//     o_flush_cnt               : redirects accepted
// ---------------------------------------------------------------------------
module ysyx_22050078_pipe_ctrl
    import ysyx_22050078_pipe_ctrl_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [REG_AW-1:0] i_idu_rs1,
    input  logic              i_idu_rs1_en,
    input  logic [REG_AW-1:0] i_idu_rs2,
    input  logic              i_idu_rs2_en,
    input  logic [REG_AW-1:0] i_exu_rd,
    input  logic              i_exu_ld,
    input  logic              i_exu_redirect,
    input  logic              i_lsu_busy,
    output logic              o_pc_wen,
    output logic              o_ifid_wen,
    output logic              o_ifid_bubble,
    output logic              o_idex_wen,
    output logic              o_idex_bubble,
    output logic              o_exls_wen,
    output logic              o_lswb_wen,
    output logic              o_lswb_bubble,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam logic [3:0] FL_INIT = 4'(FLUSH_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       fl_cnt_q, fl_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             lu_haz;
    logic             flush_inc;
    pipe_ctrl_t       ctrl, ctrl_out;

    ysyx_22050078_lu_detect #(.REG_AW(REG_AW)) u_lu_detect (
        .i_idu_rs1    (i_idu_rs1),
        .i_idu_rs1_en (i_idu_rs1_en),
        .i_idu_rs2    (i_idu_rs2),
        .i_idu_rs2_en (i_idu_rs2_en),
        .i_exu_rd     (i_exu_rd),
        .i_exu_ld     (i_exu_ld),
        .o_lu_haz     (lu_haz)
    );

    // Priority: busy > redirect > FLUSH > load-use > normal.
    // MEM_WAIT with busy low simply falls through to the RUN rules, so a
    // redirect held in EX during the wait is taken on the first free cycle.
    always_comb begin
        ctrl      = ctrl_run();
        state_d   = state_q;
        fl_cnt_d  = fl_cnt_q;
        flush_inc = 1'b0;
        if (i_lsu_busy) begin
            ctrl    = ctrl_busy();
            state_d = ST_MEM_WAIT;   // also drops any remaining flush cycles
        end else if (i_exu_redirect) begin
            ctrl.ifid_bubble = 1'b1;
            ctrl.idex_bubble = 1'b1;
            flush_inc        = 1'b1;
            if (FLUSH_CYC > 1) begin
                state_d  = ST_FLUSH;
                fl_cnt_d = FL_INIT;
            end else begin
                state_d  = ST_RUN;
            end
        end else if (state_q == ST_FLUSH) begin
            // ID holds a bubble here, so load-use is irrelevant.
            ctrl.ifid_bubble = 1'b1;
            fl_cnt_d         = fl_cnt_q - 4'd1;
            if (fl_cnt_q <= 4'd1) state_d = ST_RUN;
        end else begin
            state_d = ST_RUN;
            // Single-cycle stall: next cycle the load is in LS and the
            // hazard clears on its own, so no state is needed.
            if (lu_haz) begin
                ctrl.pc_wen      = 1'b0;
                ctrl.ifid_wen    = 1'b0;
                ctrl.idex_bubble = 1'b1;
            end
        end
    end

    assign ctrl_out = i_rst_n ? ctrl : ctrl_reset();

    assign o_pc_wen      = ctrl_out.pc_wen;
    assign o_ifid_wen    = ctrl_out.ifid_wen;
    assign o_ifid_bubble = ctrl_out.ifid_bubble;
    assign o_idex_wen    = ctrl_out.idex_wen;
    assign o_idex_bubble = ctrl_out.idex_bubble;
    assign o_exls_wen    = ctrl_out.exls_wen;
    assign o_lswb_wen    = ctrl_out.lswb_wen;
    assign o_lswb_bubble = ctrl_out.lswb_bubble;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            fl_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            fl_cnt_q <= fl_cnt_d;
            if (!ctrl.pc_wen) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc)    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_ysyx_22050078_pipe_ctrl.sv
module tb_ysyx_22050078_pipe_ctrl;

    localparam int REG_AW    = 5;
    localparam int FLUSH_CYC = 3;
    localparam int CNT_W     = 32;

    // {pc_wen, ifid_wen, ifid_bubble, idex_wen, idex_bubble, exls_wen, lswb_wen, lswb_bubble}
    localparam logic [7:0] C_NORM  = 8'b1101_0110;
    localparam logic [7:0] C_LUHAZ = 8'b0001_1110;
    localparam logic [7:0] C_REDIR = 8'b1111_1110;
    localparam logic [7:0] C_FLUSH = 8'b1111_0110;
    localparam logic [7:0] C_BUSY  = 8'b0000_0011;
    localparam logic [7:0] C_RESET = 8'b0010_1001;

    logic              clk, rst_n;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              rs1_en, rs2_en, ld, redirect, busy;
    logic              pc_wen, ifid_wen, ifid_bubble, idex_wen, idex_bubble;
    logic              exls_wen, lswb_wen, lswb_bubble;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int checks = 0;
    int failures = 0;
    int stall_exp = 0;
    int flush_exp = 0;

    ysyx_22050078_pipe_ctrl #(.REG_AW(REG_AW), .FLUSH_CYC(FLUSH_CYC), .CNT_W(CNT_W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_idu_rs1      (rs1),
        .i_idu_rs1_en   (rs1_en),
        .i_idu_rs2      (rs2),
        .i_idu_rs2_en   (rs2_en),
        .i_exu_rd       (rd),
        .i_exu_ld       (ld),
        .i_exu_redirect (redirect),
        .i_lsu_busy     (busy),
        .o_pc_wen       (pc_wen),
        .o_ifid_wen     (ifid_wen),
        .o_ifid_bubble  (ifid_bubble),
        .o_idex_wen     (idex_wen),
        .o_idex_bubble  (idex_bubble),
        .o_exls_wen     (exls_wen),
        .o_lswb_wen     (lswb_wen),
        .o_lswb_bubble  (lswb_bubble),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string             name;
        logic [REG_AW-1:0] rs1;
        logic              rs1_en;
        logic [REG_AW-1:0] rs2;
        logic              rs2_en;
        logic [REG_AW-1:0] rd;
        logic              ld;
        logic [7:0]        exp;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [7:0] ctrl_now();
        return {pc_wen, ifid_wen, ifid_bubble, idex_wen, idex_bubble, exls_wen, lswb_wen, lswb_bubble};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs are already set (low clock phase); check controls, update the
    // counter model, then advance to the next falling edge.
    task automatic cyc(input string name, input logic [7:0] exp);
        #1;
        chk(name, 32'(ctrl_now()), 32'(exp));
        if (!exp[7]) stall_exp++;
        if (exp == C_REDIR) flush_exp++;
        @(negedge clk);
    endtask

    task automatic chk_cnt(input string name);
        chk({name, "_stall_cnt"}, stall_cnt, 32'(stall_exp));
        chk({name, "_flush_cnt"}, flush_cnt, 32'(flush_exp));
    endtask

    task automatic idle();
        rs1 = '0; rs2 = '0; rd = '0; rs1_en = 0; rs2_en = 0; ld = 0;
        redirect = 0; busy = 0;
    endtask

    initial begin
        vecs[0] = '{"ld_x5_rs1",      5'd5,  1'b1, 5'd0, 1'b0, 5'd5,  1'b1, C_LUHAZ};
        vecs[1] = '{"after_ld",       5'd5,  1'b1, 5'd0, 1'b0, 5'd5,  1'b0, C_NORM};
        vecs[2] = '{"ld_x0",          5'd0,  1'b1, 5'd0, 1'b1, 5'd0,  1'b1, C_NORM};
        vecs[3] = '{"rs2_dis_match",  5'd1,  1'b1, 5'd7, 1'b0, 5'd7,  1'b1, C_NORM};
        vecs[4] = '{"rs2_match",      5'd1,  1'b1, 5'd7, 1'b1, 5'd7,  1'b1, C_LUHAZ};
        vecs[5] = '{"nonload_match",  5'd9,  1'b1, 5'd9, 1'b1, 5'd9,  1'b0, C_NORM};
        vecs[6] = '{"ld_x31",         5'd31, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, C_LUHAZ};
        vecs[7] = '{"ld_no_match",    5'd3,  1'b1, 5'd5, 1'b1, 5'd4,  1'b1, C_NORM};
        vecs[8] = '{"rs1_dis_match",  5'd4,  1'b0, 5'd5, 1'b1, 5'd4,  1'b1, C_NORM};

        idle();
        rst_n = 1'b0;
        #2;
        chk("reset_ctrl", 32'(ctrl_now()), 32'(C_RESET));
        chk_cnt("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // load-use table
        for (int i = 0; i < 9; i++) begin
            rs1 = vecs[i].rs1; rs1_en = vecs[i].rs1_en;
            rs2 = vecs[i].rs2; rs2_en = vecs[i].rs2_en;
            rd  = vecs[i].rd;  ld     = vecs[i].ld;
            cyc(vecs[i].name, vecs[i].exp);
        end
        chk_cnt("table");

        // redirect with FLUSH_CYC=3; load-use ignored while flushing
        idle(); redirect = 1;
        cyc("redir_c1", C_REDIR);
        redirect = 0; rs1 = 5'd6; rs1_en = 1; rd = 5'd6; ld = 1;
        cyc("flush_c2", C_FLUSH);
        cyc("flush_c3", C_FLUSH);
        cyc("flush_done_luhaz", C_LUHAZ);
        idle();
        cyc("flush_after", C_NORM);
        chk_cnt("flush");

        // busy 4 cycles with redirect held, redirect taken in cycle 5
        busy = 1; redirect = 1;
        for (int i = 0; i < 4; i++) cyc("busy_hold", C_BUSY);
        busy = 0;
        cyc("busy_then_redir", C_REDIR);
        redirect = 0;
        cyc("busy_flush_c2", C_FLUSH);
        cyc("busy_flush_c3", C_FLUSH);
        cyc("busy_after", C_NORM);
        chk_cnt("busy");

        // load-use and redirect together: redirect wins
        rs2 = 5'd8; rs2_en = 1; rd = 5'd8; ld = 1; redirect = 1;
        cyc("luhaz_vs_redir", C_REDIR);
        idle();
        cyc("lvr_flush_c2", C_FLUSH);
        cyc("lvr_flush_c3", C_FLUSH);
        cyc("lvr_after", C_NORM);

        // busy preempts FLUSH, remaining flush cycles dropped
        redirect = 1;
        cyc("pre_redir", C_REDIR);
        redirect = 0; busy = 1;
        cyc("pre_busy", C_BUSY);
        busy = 0;
        cyc("pre_after", C_NORM);
        chk_cnt("preempt");

        // async reset inside FLUSH
        redirect = 1;
        cyc("rst_redir", C_REDIR);
        redirect = 0;
        #1;
        chk("rst_in_flush", 32'(ctrl_now()), 32'(C_FLUSH));
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl", 32'(ctrl_now()), 32'(C_RESET));
        stall_exp = 0; flush_exp = 0;
        chk_cnt("rst_async");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        cyc("rst_release_run", C_NORM);
        chk_cnt("rst_release");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
